// File: rtl/radix2_div_32_sequential_pkg.sv
// Shared definitions for the radix-2 sequential divider: default operand width,
// fixed-point fraction bits and the packed layout of the latched operand flags.
package radix2_div_32_sequential_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SCALE = 17;

    // Sign information captured alongside the divisor magnitude at the start edge.
    typedef struct packed {
        logic resultNeg;
        logic dividendNeg;
    } opFlags_t;

endpackage

// File: rtl/FFD_POSEDGE_SYNCRONOUS_RESET.sv
// Enabled D flip-flop bank with synchronous active-high reset, reused as the
// divider's operand latch.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
    parameter int SIZE = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/radix2_div_32_sequential.sv
// Signed restoring radix-2 divider, one quotient bit per cycle, integer or fixed-point.
// Optional macro DIVIDER_SATURATE_EN clamps overflowing quotients instead of wrapping.
module radix2_div_32_sequential
    import radix2_div_32_sequential_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SCALE = DEFAULT_SCALE
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             iUnscaled,
    input  logic             iInputReady,
    output logic [WIDTH-1:0] R,
    output logic             OutputReady,
    output logic             oBusy,
    output logic             oDivByZero
);

    localparam int N  = WIDTH + SCALE;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       stateReg;
    logic [CW-1:0]    iterReg;
    // Holds the dividend bits first; quotient bits shift in from the bottom.
    logic [N-1:0]     numReg;
    logic [WIDTH-1:0] remReg;

    logic [WIDTH-1:0] absA, absB, divisorMag;
    logic [N-1:0]     numLoad;
    logic             start;
    opFlags_t         flagsIn, flagsReg;

    logic [WIDTH:0]   trial, diff;
    logic             qBit;
    logic [WIDTH-1:0] newRem;
    logic [WIDTH-1:0] wrapped, resultNext;
    logic             divZero;

    assign start   = (stateReg == IDLE) && iInputReady;
    assign oBusy   = (stateReg != IDLE);
    assign absA    = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign absB    = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign numLoad = iUnscaled ? {{SCALE{1'b0}}, absA} : {absA, {SCALE{1'b0}}};

    assign flagsIn.resultNeg   = A[WIDTH-1] ^ B[WIDTH-1];
    assign flagsIn.dividendNeg = A[WIDTH-1];

    FFD_POSEDGE_SYNCRONOUS_RESET #(
        .SIZE(WIDTH + 2)
    ) operandLatch (
        .Clock (Clock),
        .Reset (Reset),
        .Enable(start),
        .D     ({flagsIn, absB}),
        .Q     ({flagsReg, divisorMag})
    );

    // Remainder stays below the divisor, so one extra bit covers the shifted trial.
    assign trial  = {remReg, numReg[N-1]};
    assign diff   = trial - {1'b0, divisorMag};
    assign qBit   = ~diff[WIDTH];
    assign newRem = qBit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    assign divZero = (divisorMag == '0);
    assign wrapped = flagsReg.resultNeg ? (~numReg[WIDTH-1:0] + 1'b1) : numReg[WIDTH-1:0];

    always_comb begin
        resultNext = wrapped;
`ifdef DIVIDER_SATURATE_EN
        if (!flagsReg.resultNeg && (numReg > N'(MAX_POS))) begin
            resultNext = MAX_POS;
        end else if (flagsReg.resultNeg && (numReg > N'(MIN_NEG))) begin
            resultNext = MIN_NEG;
        end
`endif
        if (divZero) begin
            resultNext = flagsReg.dividendNeg ? MIN_NEG : MAX_POS;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg    <= IDLE;
            iterReg     <= '0;
            numReg      <= '0;
            remReg      <= '0;
            R           <= '0;
            OutputReady <= 1'b0;
            oDivByZero  <= 1'b0;
        end else begin
            OutputReady <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (iInputReady) begin
                        numReg   <= numLoad;
                        remReg   <= '0;
                        iterReg  <= '0;
                        stateReg <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    numReg  <= {numReg[N-2:0], qBit};
                    remReg  <= newRem;
                    iterReg <= iterReg + 1'b1;
                    if (iterReg == CW'(N - 1)) begin
                        stateReg <= FINISH;
                    end
                end
                FINISH: begin
                    R           <= resultNext;
                    oDivByZero  <= divZero;
                    OutputReady <= 1'b1;
                    iterReg     <= '0;
                    stateReg    <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_div_32_sequential.sv
// Self-checking bench for radix2_div_32_sequential: directed cases, random operands
// against an arithmetic reference model, and control/reset boundary checks.
module tb_radix2_div_32_sequential;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] A, B;
    logic        iUnscaled;
    logic        iInputReady;
    logic [31:0] R;
    logic        OutputReady;
    logic        oBusy;
    logic        oDivByZero;

    int errors = 0;
    int checks = 0;

    radix2_div_32_sequential dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .A          (A),
        .B          (B),
        .iUnscaled  (iUnscaled),
        .iInputReady(iInputReady),
        .R          (R),
        .OutputReady(OutputReady),
        .oBusy      (oBusy),
        .oDivByZero (oDivByZero)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division of magnitudes, sign from the operand sign bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic u,
                                  output logic [31:0] r, output logic dz);
        longint sa, sb, ma, mb, num, q, sq;
        logic   neg;
        sa = $signed(a);
        sb = $signed(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (mb == 0) begin
            dz = 1'b1;
            r  = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return;
        end
        dz  = 1'b0;
        num = u ? ma : (ma << 17);
        q   = num / mb;
        neg = (sa < 0) != (sb < 0);
        sq  = neg ? -q : q;
`ifdef DIVIDER_SATURATE_EN
        if (sq > 64'sd2147483647) sq = 64'sd2147483647;
        else if (sq < -64'sd2147483648) sq = -64'sd2147483648;
`endif
        r = sq[31:0];
    endfunction

    // One transaction; pokeAt >= 0 raises iInputReady with other operands mid-operation.
    task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic u,
                        input int pokeAt, input string tag);
        logic [31:0] er;
        logic        ed;
        int          lat;
        model(a, b, u, er, ed);
        @(negedge Clock);
        A = a; B = b; iUnscaled = u; iInputReady = 1'b1;
        @(negedge Clock);
        iInputReady = 1'b0;
        A = $urandom; B = $urandom | 32'h1; iUnscaled = ~u;
        chk({tag, ".busy"}, 32'(oBusy), 32'd1);
        lat = 0;
        while (!OutputReady && lat < 100) begin
            @(negedge Clock);
            lat++;
            iInputReady = (lat == pokeAt);
        end
        iInputReady = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd50);
        chk({tag, ".R"}, R, er);
        chk({tag, ".divByZero"}, 32'(oDivByZero), 32'(ed));
        $display("op %s A=%h B=%h u=%0d -> R=%h dz=%0d lat=%0d", tag, a, b, u, R, oDivByZero, lat);
        @(negedge Clock);
        chk({tag, ".pulseEnd"}, 32'(OutputReady), 32'd0);
        chk({tag, ".hold"}, R, er);
        chk({tag, ".idle"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic        ed;
        int          gap, pulses, waitCnt;

        Reset = 1'b1; A = '0; B = '0; iUnscaled = 1'b0; iInputReady = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset.R", R, 32'h0);
        chk("reset.OutputReady", 32'(OutputReady), 32'd0);
        chk("reset.oBusy", 32'(oBusy), 32'd0);
        chk("reset.oDivByZero", 32'(oDivByZero), 32'd0);
        Reset = 1'b0;

        doOp(32'h000C_0000, 32'h0004_0000, 1'b0, -1, "scaled6div2");
        chk("scaled6div2.spec", R, 32'h0006_0000);
        doOp(32'd100, 32'd7, 1'b1, -1, "int100div7");
        chk("int100div7.spec", R, 32'd14);
        doOp(-32'sd100, 32'd7, 1'b1, -1, "intNeg100div7");
        chk("intNeg100div7.spec", R, 32'hFFFF_FFF2);
        doOp(32'hFFF4_0000, 32'h0004_0000, 1'b0, -1, "scaledNeg6div2");
        chk("scaledNeg6div2.spec", R, 32'hFFFA_0000);
        doOp(32'd5, 32'd0, 1'b1, -1, "pos5div0");
        chk("pos5div0.spec", R, 32'h7FFF_FFFF);
        doOp(-32'sd5, 32'd0, 1'b1, -1, "neg5div0");
        chk("neg5div0.spec", R, 32'h8000_0000);
        doOp(32'h7FFF_FFFF, 32'd1, 1'b0, -1, "overflow");
`ifdef DIVIDER_SATURATE_EN
        chk("overflow.spec", R, 32'h7FFF_FFFF);
`else
        chk("overflow.spec", R, 32'hFFFE_0000);
`endif
        doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "minDivNeg1");
        doOp(32'h8000_0000, 32'd3, 1'b1, -1, "minDiv3");

        doOp(32'd1000, 32'd9, 1'b1, 20, "ignoreMid");
        doOp(32'd1000, 32'd9, 1'b1, 49, "ignoreFinish");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 4096);
                2: rb = -$urandom_range(1, 70000);
                default: rb = (i == 7) ? 32'h0 : ($urandom | 32'h0001_0000);
            endcase
            doOp(ra, rb, 1'(i % 2), -1, $sformatf("rand%0d", i));
        end

        // Request held high: results every N+2 cycles.
        model(32'd123456, 32'd321, 1'b1, er, ed);
        @(negedge Clock);
        A = 32'd123456; B = 32'd321; iUnscaled = 1'b1; iInputReady = 1'b1;
        waitCnt = 0;
        while (!OutputReady && waitCnt < 100) begin
            @(negedge Clock);
            waitCnt++;
        end
        chk("b2b.first.R", R, er);
        gap = 0;
        do begin
            @(negedge Clock);
            gap++;
        end while (!OutputReady && gap < 100);
        chk("b2b.gap", 32'(gap), 32'd51);
        chk("b2b.second.R", R, er);
        $display("op b2b A=%h B=%h -> R=%h gap=%0d", A, B, R, gap);
        iInputReady = 1'b0;
        waitCnt = 0;
        while (oBusy && waitCnt < 100) begin
            @(negedge Clock);
            waitCnt++;
        end
        chk("b2b.drain", 32'(oBusy), 32'd0);
        repeat (2) @(negedge Clock);

        // Reset in the middle of DIVIDE.
        A = 32'd77777; B = 32'd13; iUnscaled = 1'b1; iInputReady = 1'b1;
        @(negedge Clock);
        iInputReady = 1'b0;
        repeat (20) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("midReset.R", R, 32'h0);
        chk("midReset.OutputReady", 32'(OutputReady), 32'd0);
        chk("midReset.oBusy", 32'(oBusy), 32'd0);
        chk("midReset.oDivByZero", 32'(oDivByZero), 32'd0);
        pulses = 0;
        repeat (60) begin
            @(negedge Clock);
            if (OutputReady) pulses++;
        end
        chk("midReset.noPulse", 32'(pulses), 32'd0);
        $display("op midReset -> R=%h pulses=%0d", R, pulses);

        // Reset wins over a simultaneous start request.
        Reset = 1'b1; iInputReady = 1'b1; A = 32'd50; B = 32'd5;
        @(negedge Clock);
        Reset = 1'b0; iInputReady = 1'b0;
        chk("resetStart.oBusy", 32'(oBusy), 32'd0);
        pulses = 0;
        repeat (60) begin
            @(negedge Clock);
            if (OutputReady) pulses++;
        end
        chk("resetStart.noPulse", 32'(pulses), 32'd0);
        $display("op resetStart -> busy=%0d pulses=%0d", oBusy, pulses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
